exception_controller: RTL and testbench

Sequential consumer of the 2-bit exception ID produced by the datapath's priority encoder. It latches the winning exception, saves the faulting PC into EPC, records the cause, and redirects fetch to a per-cause handler vector with a one-cycle pipeline flush. It then holds the core in handler mode until an `eret` returns fetch to EPC. It sits between the exception-source logic and the PC-select mux of the pipelined MIPS core.

---
 rtl/exception_controller.sv | 94 +++++++++
 tb/tb_exception_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exception_controller.sv
// Exception sequencer: latches the winning cause and EPC, redirects fetch to a per-cause vector, and returns to EPC on eret.
// Latency: redirect outputs assert the cycle after the request is sampled; the return redirect asserts the cycle after eret.
// Backpressure: none; requests arriving outside IDLE are dropped, and an interrupt source must hold its request until int_ack.
module exception_controller #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0180,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_req,
    input  logic [1:0]       exc_id,
    input  logic             int_en,
    input  logic [31:0]      pc_in,
    input  logic             eret,
    output logic [1:0]       pc_sel,
    output logic [31:0]      pc_target,
    output logic             flush,
    output logic             int_ack,
    output logic             in_handler,
    output logic [31:0]      epc,
    output logic [1:0]       cause,
    output logic             double_fault,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {IDLE, REDIRECT, HANDLER, RETURN} state_t;

    state_t      state;
    logic        take;
    logic [31:0] vector;

    // An external interrupt only qualifies while interrupts are enabled.
    assign take   = exc_req && ((exc_id != 2'd3) || int_en);
    assign vector = VECTOR_BASE + {26'd0, exc_id, 4'b0000};

    // All outputs are computed for the state being entered, so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc_sel       <= 2'd0;
            pc_target    <= 32'd0;
            flush        <= 1'b0;
            int_ack      <= 1'b0;
            in_handler   <= 1'b0;
            epc          <= 32'd0;
            cause        <= 2'd0;
            double_fault <= 1'b0;
            exc_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state      <= REDIRECT;
                        epc        <= pc_in;
                        cause      <= exc_id;
                        pc_sel     <= 2'd1;
                        pc_target  <= vector;
                        flush      <= 1'b1;
                        int_ack    <= (exc_id == 2'd3);
                        in_handler <= 1'b1;
                        if (exc_count != {CNT_W{1'b1}})
                            exc_count <= exc_count + 1'b1;
                    end
                end
                REDIRECT: begin
                    state     <= HANDLER;
                    pc_sel    <= 2'd0;
                    pc_target <= 32'd0;
                    flush     <= 1'b0;
                    int_ack   <= 1'b0;
                end
                HANDLER: begin
                    if (eret) begin
                        state      <= RETURN;
                        pc_sel     <= 2'd2;
                        pc_target  <= epc;
                        flush      <= 1'b1;
                        in_handler <= 1'b0;
                    end else if (exc_req && (exc_id != 2'd3)) begin
                        // Nested synchronous fault: flag it but keep the original EPC/cause.
                        double_fault <= 1'b1;
                    end
                end
                RETURN: begin
                    state     <= IDLE;
                    pc_sel    <= 2'd0;
                    pc_target <= 32'd0;
                    flush     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed vector table, async-reset corner case, random traffic and counter saturation.
module tb_exception_controller;

    localparam logic [31:0] BASE = 32'h0000_0180;

    logic        clk;
    logic        rst;
    logic        exc_req;
    logic [1:0]  exc_id;
    logic        int_en;
    logic [31:0] pc_in;
    logic        eret;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        flush;
    logic        int_ack;
    logic        in_handler;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        double_fault;
    logic [7:0]  exc_count;

    exception_controller #(.VECTOR_BASE(BASE), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .exc_req(exc_req), .exc_id(exc_id), .int_en(int_en),
        .pc_in(pc_in), .eret(eret), .pc_sel(pc_sel), .pc_target(pc_target),
        .flush(flush), .int_ack(int_ack), .in_handler(in_handler), .epc(epc),
        .cause(cause), .double_fault(double_fault), .exc_count(exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: phase 0 idle, 1 redirect, 2 handler, 3 return.
    int          ph;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    int          m_cnt;
    bit          m_df;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        ph = 0; m_epc = 32'd0; m_cause = 2'd0; m_cnt = 0; m_df = 1'b0;
    endtask

    task automatic model_step();
        case (ph)
            0: if (exc_req && (exc_id != 2'd3 || int_en)) begin
                   m_epc = pc_in; m_cause = exc_id;
                   if (m_cnt < 255) m_cnt++;
                   ph = 1;
               end
            1: ph = 2;
            2: if (eret) ph = 3;
               else if (exc_req && exc_id != 2'd3) m_df = 1'b1;
            default: ph = 0;
        endcase
    endtask

    task automatic check_model();
        logic [31:0] e_tgt;
        logic [1:0]  e_sel;
        e_sel = (ph == 1) ? 2'd1 : (ph == 3) ? 2'd2 : 2'd0;
        e_tgt = (ph == 1) ? BASE + 32'(m_cause) * 32'd16 : (ph == 3) ? m_epc : 32'd0;
        chk("m_pc_sel", 32'(pc_sel), 32'(e_sel));
        chk("m_pc_target", pc_target, e_tgt);
        chk("m_flush", 32'(flush), 32'(ph == 1 || ph == 3));
        chk("m_int_ack", 32'(int_ack), 32'(ph == 1 && m_cause == 2'd3));
        chk("m_in_handler", 32'(in_handler), 32'(ph == 1 || ph == 2));
        chk("m_epc", epc, m_epc);
        chk("m_cause", 32'(cause), 32'(m_cause));
        chk("m_exc_count", 32'(exc_count), 32'(m_cnt));
        chk("m_double_fault", 32'(double_fault), 32'(m_df));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc_sel"}, 32'(pc_sel), 32'd0);
        chk({tag, "_pc_target"}, pc_target, 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_int_ack"}, 32'(int_ack), 32'd0);
        chk({tag, "_in_handler"}, 32'(in_handler), 32'd0);
        chk({tag, "_epc"}, epc, 32'd0);
        chk({tag, "_cause"}, 32'(cause), 32'd0);
        chk({tag, "_double_fault"}, 32'(double_fault), 32'd0);
        chk({tag, "_exc_count"}, 32'(exc_count), 32'd0);
    endtask

    typedef struct {
        logic        req;
        logic [1:0]  id;
        logic        ien;
        logic [31:0] pc;
        logic        er;
        logic [1:0]  e_sel;
        logic [31:0] e_tgt;
        logic        e_flush;
        logic        e_ack;
        logic        e_inh;
        logic [31:0] e_epc;
        logic [1:0]  e_cause;
        logic [7:0]  e_cnt;
        logic        e_df;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h0040_0010, 1'b0, 2'd1, 32'h0000_01A0, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 2'd2, 8'd1, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0040_0010, 2'd2, 8'd1, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h0,         1'b1, 2'd2, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 2'd2, 8'd1, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0040_0010, 2'd2, 8'd1, 1'b0};
        for (int i = 4; i <= 8; i++)
            tbl[i] = '{1'b1, 2'd3, 1'b0, 32'h0000_0500, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 2'd2, 8'd1, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 32'h0040_0020, 1'b0, 2'd1, 32'h0000_01B0, 1'b1, 1'b1, 1'b1, 32'h0040_0020, 2'd3, 8'd2, 1'b0};
        tbl[10] = '{1'b1, 2'd3, 1'b1, 32'h0040_0020, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0040_0020, 2'd3, 8'd2, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b1, 32'h0000_0999, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0040_0020, 2'd3, 8'd2, 1'b1};
        tbl[12] = '{1'b1, 2'd0, 1'b1, 32'h0000_0888, 1'b1, 2'd2, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0040_0020, 2'd3, 8'd2, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0040_0020, 2'd3, 8'd2, 1'b1};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h0,         1'b1, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0040_0020, 2'd3, 8'd2, 1'b1};

        exc_req = 1'b0; exc_id = 2'd0; int_en = 1'b0; pc_in = 32'd0; eret = 1'b0;
        rst = 1'b1;
        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            exc_req = tbl[i].req; exc_id = tbl[i].id; int_en = tbl[i].ien;
            pc_in = tbl[i].pc; eret = tbl[i].er;
            tick();
            chk($sformatf("t%0d_pc_sel", i), 32'(pc_sel), 32'(tbl[i].e_sel));
            chk($sformatf("t%0d_pc_target", i), pc_target, tbl[i].e_tgt);
            chk($sformatf("t%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("t%0d_int_ack", i), 32'(int_ack), 32'(tbl[i].e_ack));
            chk($sformatf("t%0d_in_handler", i), 32'(in_handler), 32'(tbl[i].e_inh));
            chk($sformatf("t%0d_epc", i), epc, tbl[i].e_epc);
            chk($sformatf("t%0d_cause", i), 32'(cause), 32'(tbl[i].e_cause));
            chk($sformatf("t%0d_exc_count", i), 32'(exc_count), 32'(tbl[i].e_cnt));
            chk($sformatf("t%0d_double_fault", i), 32'(double_fault), 32'(tbl[i].e_df));
        end

        // Reset asserted during REDIRECT clears everything before the next edge.
        exc_req = 1'b1; exc_id = 2'd0; int_en = 1'b0; pc_in = 32'h0000_1234; eret = 1'b0;
        tick();
        chk("mid_redirect_pc_sel", 32'(pc_sel), 32'd1);
        exc_req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("async_rst");
        #1;
        rst = 1'b0;
        exc_req = 1'b1; exc_id = 2'd1; pc_in = 32'h0000_2000;
        tick();
        chk("post_rst_target", pc_target, 32'h0000_0190);
        chk("post_rst_count", 32'(exc_count), 32'd1);
        exc_req = 1'b0;
        tick();
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            exc_req = ($urandom_range(0, 1) == 1);
            exc_id  = 2'($urandom_range(0, 3));
            int_en  = ($urandom_range(0, 1) == 1);
            pc_in   = $urandom;
            eret    = ($urandom_range(0, 3) == 0);
            tick();
        end
        exc_req = 1'b0; eret = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // 300 back-to-back exceptions at minimum spacing drive the counter to saturation.
        for (int n = 0; n < 300; n++) begin
            exc_req = 1'b1; exc_id = 2'($urandom_range(0, 3)); int_en = 1'b1;
            pc_in = $urandom; eret = 1'b0;
            tick();
            exc_req = ($urandom_range(0, 1) == 1);
            exc_id  = 2'($urandom_range(0, 3));
            tick();
            eret = 1'b1;
            tick();
            eret = 1'b0;
            exc_req = ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("saturated_count", 32'(exc_count), 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
